logic_gate_unit: RTL and testbench

- Parametrised, registered successor to the single-bit combinational gate: a WIDTH-bit logic unit with eight selectable operations.
- Element-wise mode: one result per input beat.
- Reduce mode: folds a frame of operand words into one result.
- Sits between board-level input logic and downstream consumers, with valid/ready handshakes on both sides.

---
 rtl/logic_unit_pkg.sv | 23 ++
 rtl/logic_gate_unit_op_core.sv | 30 +++
 rtl/logic_gate_unit.sv | 159 +++++++++++++++
 tb/tb_logic_gate_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic gate unit: operation and mode
// encodings plus the frame-control FSM state type.
package logic_unit_pkg;

   localparam logic [2:0] OP_AND    = 3'd0;
   localparam logic [2:0] OP_OR     = 3'd1;
   localparam logic [2:0] OP_XOR    = 3'd2;
   localparam logic [2:0] OP_NAND   = 3'd3;
   localparam logic [2:0] OP_NOR    = 3'd4;
   localparam logic [2:0] OP_XNOR   = 3'd5;
   localparam logic [2:0] OP_PASS_A = 3'd6;
   localparam logic [2:0] OP_NOT_A  = 3'd7;

   localparam logic MODE_ELEM = 1'b0;
   localparam logic MODE_RED  = 1'b1;

   // ST_IDLE: no reduce frame open; ST_ACC: reduce frame open
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_t;

endpackage

// File: rtl/logic_gate_unit_op_core.sv
// logic_op_core: purely combinational bitwise f(x, y, op) over WIDTH bits.
// PASS_A and NOT_A look only at x.
module logic_op_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] f
);

   // Select the bitwise function by opcode
   always_comb begin
      f = '0;
      case (op)
         OP_AND:    f = x & y;
         OP_OR:     f = x | y;
         OP_XOR:    f = x ^ y;
         OP_NAND:   f = ~(x & y);
         OP_NOR:    f = ~(x | y);
         OP_XNOR:   f = ~(x ^ y);
         OP_PASS_A: f = x;
         OP_NOT_A:  f = ~x;
         default:   f = '0;
      endcase
   end

endmodule

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered WIDTH-bit logic unit with element-wise and
// reduce (left-to-right fold over a frame) modes.
// Handshake: a beat transfers on in_valid && in_ready, a result transfers on
// out_valid && out_ready; in_ready = !out_valid || out_ready, so a new result
// may be written in the same cycle the previous one drains, and the output
// register holds steady while out_valid && !out_ready.
// Optional macro LOGIC_GATE_UNIT_PARITY_EN adds out_parity (XOR-reduce of
// out_data, registered with it).
module logic_gate_unit
   import logic_unit_pkg::*;
#(
   parameter  int WIDTH   = 8,
   parameter  int MAX_LEN = 16,
   localparam int CW      = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic             in_mode,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    out_count,
   output logic             out_trunc
`ifdef LOGIC_GATE_UNIT_PARITY_EN
   ,
   output logic             out_parity
`endif
);

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic [2:0]       op_q;
   logic             mode_q;

   logic             accept;
   logic [WIDTH-1:0] core_x;
   logic [WIDTH-1:0] core_y;
   logic [2:0]       core_op;
   logic [WIDTH-1:0] core_f;
   logic [CW-1:0]    cnt_inc;
   logic             frame_beat;
   logic             frame_close;
   logic             emit;
   logic [WIDTH-1:0] emit_data;
   logic [CW-1:0]    emit_count;
   logic             emit_trunc;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   logic_op_core #(.WIDTH(WIDTH)) u_core (
      .x  (core_x),
      .y  (core_y),
      .op (core_op),
      .f  (core_f)
   );

   // Feed the core: fresh operands when idle, accumulator and new word when a frame is open
   always_comb begin
      core_x  = in_a;
      core_y  = in_b;
      core_op = in_op;
      if (state == ST_ACC) begin
         core_x  = acc;
         core_y  = in_a;
         core_op = op_q;
      end
   end

   // Decide whether this cycle produces a result, and what it is
   always_comb begin
      cnt_inc     = cnt + CW'(1);
      frame_beat  = accept && (state == ST_ACC) && (mode_q == MODE_RED);
      frame_close = frame_beat && (in_last || (cnt_inc == CW'(MAX_LEN)));
      emit        = 1'b0;
      emit_data   = '0;
      emit_count  = '0;
      emit_trunc  = 1'b0;
      if (state == ST_IDLE) begin
         if (accept && (in_mode == MODE_ELEM)) begin
            emit       = 1'b1;
            emit_data  = core_f;
            emit_count = CW'(1);
         end else if (accept && in_last) begin
            // single-beat reduce frame: the fold of one word is the word itself
            emit       = 1'b1;
            emit_data  = in_a;
            emit_count = CW'(1);
         end
      end else if (frame_close) begin
         emit       = 1'b1;
         emit_data  = core_f;
         emit_count = cnt_inc;
         emit_trunc = !in_last;
      end
   end

   // Frame FSM, accumulator, beat counter and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         acc        <= '0;
         cnt        <= '0;
         op_q       <= OP_AND;
         mode_q     <= MODE_ELEM;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_count  <= '0;
         out_trunc  <= 1'b0;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
         out_parity <= 1'b0;
`endif
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (emit) begin
            out_valid  <= 1'b1;
            out_data   <= emit_data;
            out_count  <= emit_count;
            out_trunc  <= emit_trunc;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
            out_parity <= ^emit_data;
`endif
         end
         case (state)
            ST_IDLE: begin
               if (accept && (in_mode == MODE_RED)) begin
                  op_q   <= in_op;
                  mode_q <= in_mode;
                  acc    <= in_a;
                  cnt    <= CW'(1);
                  if (!in_last) begin
                     state <= ST_ACC;
                  end
               end
            end
            ST_ACC: begin
               if (frame_beat) begin
                  acc <= core_f;
                  cnt <= cnt_inc;
                  if (frame_close) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Testbench for logic_gate_unit: directed steps followed by a randomized
// phase, scored against a frame-level reference model.
// Build with LOGIC_GATE_UNIT_PARITY_EN to cover out_parity.
module tb_logic_gate_unit;
   import logic_unit_pkg::*;

   localparam int W  = 8;
   localparam int ML = 16;
   localparam int CW = $clog2(ML + 1);
   localparam int EW = W + CW + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [2:0]    in_op;
   logic          in_mode;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [CW-1:0] out_count;
   logic          out_trunc;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
   logic          out_parity;
`endif

   // clock / reset
   always #5 clk = ~clk;

   logic_gate_unit #(.WIDTH(W), .MAX_LEN(ML)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .in_mode   (in_mode),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_trunc (out_trunc)
`ifdef LOGIC_GATE_UNIT_PARITY_EN
      ,
      .out_parity (out_parity)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;
   int stalls   = 0;
   bit rand_bp  = 1'b0;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] obs_q[$];

   // reference model state: the open frame as a list of words
   bit            fr_open = 1'b0;
   logic [2:0]    fr_op;
   logic [W-1:0]  fr_beats[$];

   // per-bit truth tables indexed by {x_bit, y_bit}, one per opcode
   logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                          4'b0001, 4'b1001, 4'b1100, 4'b0011};

   function automatic logic [W-1:0] ref_f(input logic [2:0] op,
                                          input logic [W-1:0] x,
                                          input logic [W-1:0] y);
      logic [W-1:0] r;
      logic [3:0]   t;
      t = tt[op];
      for (int i = 0; i < W; i++) r[i] = t[{x[i], y[i]}];
      return r;
   endfunction

   function automatic logic [EW-1:0] pk(input logic [W-1:0] d,
                                        input logic [CW-1:0] c,
                                        input logic t);
      return {d, c, t};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic close_frame(input logic trunc);
      logic [W-1:0] r;
      r = fr_beats[0];
      for (int i = 1; i < fr_beats.size(); i++) r = ref_f(fr_op, r, fr_beats[i]);
      exp_q.push_back(pk(r, CW'(fr_beats.size()), trunc));
      fr_open = 1'b0;
   endtask

   task automatic model_accept(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input logic mode, input logic last);
      if (!fr_open) begin
         if (mode == MODE_ELEM) begin
            exp_q.push_back(pk(ref_f(op, a, b), CW'(1), 1'b0));
         end else begin
            fr_op = op;
            fr_beats.delete();
            fr_beats.push_back(a);
            if (last) close_frame(1'b0);
            else fr_open = 1'b1;
         end
      end else begin
         fr_beats.push_back(a);
         if (last) close_frame(1'b0);
         else if (fr_beats.size() == ML) close_frame(1'b1);
      end
   endtask

   // driver: present one beat from posedge+1, wait for in_ready (bounded)
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic mode, input logic last);
      int  waited;
      bit  ok;
      waited = 0;
      ok     = 1'b0;
      in_a = a; in_b = b; in_op = op; in_mode = mode; in_last = last;
      in_valid = 1'b1;
      while (!ok) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
         end else begin
            stalls++;
            waited++;
            if (waited > 200) begin
               check("send_timeout", 32'(waited), 32'(0));
               break;
            end
            @(posedge clk); #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
         end
      end
      if (ok) model_accept(a, b, op, mode, last);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      end
   endtask

   // scoreboard: every transferred result against the model's expected queue
   always @(negedge clk) begin : mon
      logic [EW-1:0] obs;
      logic [EW-1:0] exp;
      if (rst_n && out_valid && out_ready) begin
         obs = pk(out_data, out_count, out_trunc);
         obs_q.push_back(obs);
         exp = 'x;
         if (exp_q.size() > 0) exp = exp_q.pop_front();
         check("result", 32'(obs), 32'(exp));
`ifdef LOGIC_GATE_UNIT_PARITY_EN
         check("parity_track", 32'(out_parity), 32'(^exp[EW-1 -: W]));
`endif
      end
   end

   logic [W-1:0] elem_exp [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0, 8'h0F};
   int stalls_before;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
      in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'(0));
      check("rst_data",  32'(out_data),  32'(0));
      check("rst_count", 32'(out_count), 32'(0));
      check("rst_trunc", 32'(out_trunc), 32'(0));
      check("rst_ready", 32'(in_ready),  32'(1));
`ifdef LOGIC_GATE_UNIT_PARITY_EN
      check("rst_parity", 32'(out_parity), 32'(0));
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // element-wise, all eight ops back to back
      obs_q.delete();
      stalls = 0;
      for (int i = 0; i < 8; i++) send(8'hF0, 8'h3C, 3'(i), MODE_ELEM, 1'b0);
      wait_cycles(3);
      check("elem_n", 32'(obs_q.size()), 32'(8));
      for (int i = 0; i < 8; i++) check("elem_res", 32'(obs_q[i]), 32'(pk(elem_exp[i], CW'(1), 1'b0)));
      check("elem_stalls", 32'(stalls), 32'(0));

      // reduce XOR; later beats carry a different op/mode which must be ignored
      obs_q.delete();
      send(8'h01, 8'h00, OP_XOR, MODE_RED, 1'b0);
      send(8'h02, 8'h00, OP_AND, MODE_ELEM, 1'b0);
      wait_cycles(2);
      check("red_early", 32'(obs_q.size()), 32'(0));
      send(8'h04, 8'h00, OP_NOR, MODE_ELEM, 1'b1);
      wait_cycles(2);
      check("red_n", 32'(obs_q.size()), 32'(1));
      check("red_res", 32'(obs_q[0]), 32'(pk(8'h07, CW'(3), 1'b0)));

      // truncation at MAX_LEN, then a new frame of beats 17, 18 and a closing beat
      obs_q.delete();
      for (int i = 0; i < 18; i++) send(W'(1 << (i % 8)), 8'h00, OP_OR, MODE_RED, 1'b0);
      send(8'h08, 8'h00, OP_OR, MODE_RED, 1'b1);
      wait_cycles(2);
      check("trunc_n", 32'(obs_q.size()), 32'(2));
      check("trunc_res", 32'(obs_q[0]), 32'(pk(8'hFF, CW'(16), 1'b1)));
      check("trunc_next", 32'(obs_q[1]), 32'(pk(8'h0B, CW'(3), 1'b0)));

      // backpressure: result held, input blocked, then same-cycle accept
      out_ready = 1'b0;
      send(8'h5A, 8'h0F, OP_XOR, MODE_ELEM, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_ready", 32'(in_ready),  32'(0));
         check("bp_valid", 32'(out_valid), 32'(1));
         check("bp_data",  32'(out_data),  32'(8'h55));
         check("bp_count", 32'(out_count), 32'(1));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      stalls_before = stalls;
      send(8'h11, 8'h22, OP_OR, MODE_ELEM, 1'b0);
      check("bp_release", 32'(stalls), 32'(stalls_before));
      wait_cycles(2);

`ifdef LOGIC_GATE_UNIT_PARITY_EN
      send(8'h07, 8'h00, OP_XOR, MODE_ELEM, 1'b0);
      @(negedge clk);
      check("parity_1", 32'(out_parity), 32'(1));
      @(posedge clk); #1;
      send(8'h03, 8'h03, OP_AND, MODE_ELEM, 1'b0);
      @(negedge clk);
      check("parity_0", 32'(out_parity), 32'(0));
      @(posedge clk); #1;
`endif

      // reset in the middle of an open frame
      send(8'h33, 8'h00, OP_AND, MODE_RED, 1'b0);
      send(8'h0F, 8'h00, OP_AND, MODE_RED, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'(0));
      check("mid_rst_data",  32'(out_data),  32'(0));
      check("mid_rst_count", 32'(out_count), 32'(0));
      check("mid_rst_trunc", 32'(out_trunc), 32'(0));
      fr_open = 1'b0;
      fr_beats.delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      obs_q.delete();
      send(8'hAA, 8'h00, OP_AND, MODE_RED, 1'b1);
      wait_cycles(2);
      check("post_rst_n", 32'(obs_q.size()), 32'(1));
      check("post_rst_res", 32'(obs_q[0]), 32'(pk(8'hAA, CW'(1), 1'b0)));

      // randomized traffic with random gaps and random backpressure
      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         wait_cycles($urandom_range(0, 2));
         send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      end
      rand_bp = 1'b0;
      out_ready = 1'b1;
      wait_cycles(10);
      check("drain_empty", 32'(exp_q.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
